// File: rtl/grey_window_3x3_pkg.sv
// Shared pixel/window types for the grey pipeline (window generator and convolution stage).
package img_pkg;

    localparam int PIX_W = 4;
    localparam int IMG_W = 320;
    localparam int IMG_H = 240;

    typedef logic [PIX_W-1:0] pixel_t;

    // Packed [r][c]: element (r,c) lands at bits PIX_W*(3r+c), r=0 oldest line, c=0 oldest column.
    typedef pixel_t [2:0][2:0] window_t;

    function automatic logic [9*PIX_W-1:0] win_pack(window_t w);
        return w;
    endfunction

    function automatic window_t win_unpack(logic [9*PIX_W-1:0] flat);
        return flat;
    endfunction

    function automatic pixel_t win_elem(window_t w, logic [1:0] r, logic [1:0] c);
        return w[r][c];
    endfunction

endpackage

// File: rtl/grey_window_3x3_if.sv
// Pixel-in / window-out bus of the 3x3 window generator.
interface grey_window_3x3_if #(
    parameter int PIX_W = img_pkg::PIX_W
);
    logic [PIX_W-1:0]   pixel_in;
    logic               in_ready;
    logic               sof;
    logic [9*PIX_W-1:0] window;
    logic               out_ready;
    logic               out_last;

    modport master (
        output pixel_in, in_ready, sof,
        input  window, out_ready, out_last
    );

    modport slave (
        input  pixel_in, in_ready, sof,
        output window, out_ready, out_last
    );
endinterface

// File: rtl/grey_window_3x3_line_buffer.sv
// One image line of storage: combinational read, synchronous write, read-before-write.
module line_buffer #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    // Contents are intentionally not reset; consumers gate stale lines by row position.
    logic [WIDTH-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge clk) begin
        if (en) mem[addr] <= wdata;
    end

endmodule

// File: rtl/grey_window_3x3.sv
// Sliding 3x3 window generator: buffers two grey lines and emits each full-interior neighbourhood.
module grey_window_3x3 #(
    parameter int IMG_W = img_pkg::IMG_W,
    parameter int IMG_H = img_pkg::IMG_H
) (
    input  logic               clk,
    input  logic               rst,
    grey_window_3x3_if.slave   bus
);
    import img_pkg::*;

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic          accept, col_end, row_end, win_hit, last_hit;
    pixel_t        l0_rd, l1_rd;
    pixel_t [2:0]  col_in;
    window_t       sr;
    logic          win_vld_q, win_last_q;

    // sof relabels the accepted pixel as (0,0) before it is addressed or counted.
    always_comb begin
        accept    = bus.in_ready;
        cur_col   = bus.sof ? '0 : col;
        cur_row   = bus.sof ? '0 : row;
        col_end   = (cur_col == CW'(IMG_W - 1));
        row_end   = (cur_row == RW'(IMG_H - 1));
        win_hit   = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        last_hit  = accept && row_end && col_end;
        col_in[0] = l0_rd;
        col_in[1] = l1_rd;
        col_in[2] = bus.pixel_in;
    end

    // line1 holds the previous line; line0 receives what line1 is about to lose.
    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line1 (
        .clk   (clk),
        .en    (accept),
        .addr  (cur_col),
        .wdata (bus.pixel_in),
        .rdata (l1_rd)
    );

    line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_line0 (
        .clk   (clk),
        .en    (accept),
        .addr  (cur_col),
        .wdata (l1_rd),
        .rdata (l0_rd)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                sr[r][0] <= sr[r][1];
                sr[r][1] <= sr[r][2];
                sr[r][2] <= col_in[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_vld_q  <= 1'b0;
            win_last_q <= 1'b0;
        end else begin
            win_vld_q  <= win_hit;
            win_last_q <= last_hit;
        end
    end

    assign bus.window    = win_pack(sr);
    assign bus.out_ready = win_vld_q;
    assign bus.out_last  = win_last_q;

endmodule

// File: tb/tb_grey_window_3x3.sv
// Scenario bench for grey_window_3x3 on a 5x4 frame with a window scoreboard.
module tb_grey_window_3x3;
    import img_pkg::*;

    localparam int W = 5;
    localparam int H = 4;

    typedef struct {
        logic [9*PIX_W-1:0] win;
        logic               last;
        int                 cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    grey_window_3x3_if bus ();

    grey_window_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t               q[$];
    logic [9*PIX_W-1:0] win_log[$];
    exp_t               e_m;
    pixel_t             hist[H][W];
    int                 mrow = 0, mcol = 0;
    int                 cyc = 0;
    int                 n_cmp = 0, n_err = 0, n_pulse = 0, n_last = 0;
    logic [9*PIX_W-1:0] first_exp, last_exp;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every out_ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.out_ready === 1'b1) begin
            n_pulse++;
            if (bus.out_last === 1'b1) n_last++;
            win_log.push_back(bus.window);
            n_cmp++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL spurious_window: out_ready=1 window=%h, none expected (cycle %0d)", bus.window, cyc);
            end else begin
                e_m = q.pop_front();
                n_cmp++;
                if (bus.window !== e_m.win) begin
                    n_err++;
                    $display("FAIL window_data: got %h expected %h", bus.window, e_m.win);
                end
                n_cmp++;
                if (bus.out_last !== e_m.last) begin
                    n_err++;
                    $display("FAIL out_last: got %b expected %b", bus.out_last, e_m.last);
                end
                n_cmp++;
                if (cyc !== e_m.cyc) begin
                    n_err++;
                    $display("FAIL latency: window in cycle %0d expected cycle %0d", cyc, e_m.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input bit s);
        pixel_t  v;
        window_t w;
        exp_t    e;
        if (s) begin
            mrow = 0;
            mcol = 0;
        end
        v = pixel_t'((5 * mrow + mcol) % 16);
        hist[mrow][mcol] = v;
        if (mrow >= 2 && mcol >= 2) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    w[r][c] = hist[mrow-2+r][mcol-2+c];
            e.win  = win_pack(w);
            e.last = (mrow == H-1) && (mcol == W-1);
            e.cyc  = cyc + 1;
            q.push_back(e);
        end
        bus.pixel_in = v;
        bus.in_ready = 1'b1;
        bus.sof      = s;
        if (mcol == W-1) begin
            mcol = 0;
            mrow = (mrow == H-1) ? 0 : mrow + 1;
        end else begin
            mcol++;
        end
        @(posedge clk);
        #1;
        bus.in_ready = 1'b0;
        bus.sof      = 1'b0;
    endtask

    task automatic idle();
        bus.in_ready = 1'b0;
        bus.sof      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_pulse = 0;
        n_last  = 0;
        win_log.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.out_ready !== 1'b0 || bus.out_last !== 1'b0 || bus.window !== '0) begin
            n_err++;
            $display("FAIL reset_held: ready=%b last=%b window=%h expected 0/0/0", bus.out_ready, bus.out_last, bus.window);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle();
            n_cmp++;
            if (bus.window !== '0) begin
                n_err++;
                $display("FAIL reset_window: got %h expected 0", bus.window);
            end
            n_cmp++;
            if (bus.out_ready !== 1'b0 || bus.out_last !== 1'b0) begin
                n_err++;
                $display("FAIL reset_flags: ready=%b last=%b expected 0/0", bus.out_ready, bus.out_last);
            end
        end
    endtask

    task automatic check_frame(input string tag, input int pulses, input int lasts, input int first_i, input int last_i);
        repeat (3) idle();
        n_cmp++;
        if (n_pulse !== pulses) begin
            n_err++;
            $display("FAIL %s_pulses: got %0d expected %0d", tag, n_pulse, pulses);
        end
        n_cmp++;
        if (n_last !== lasts) begin
            n_err++;
            $display("FAIL %s_last_count: got %0d expected %0d", tag, n_last, lasts);
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL %s_missing: %0d windows never appeared, expected 0", tag, q.size());
        end
        n_cmp++;
        if (win_log.size() <= last_i) begin
            n_err++;
            $display("FAIL %s_log: only %0d windows, expected more than %0d", tag, win_log.size(), last_i);
        end else begin
            n_cmp++;
            if (win_log[first_i] !== first_exp) begin
                n_err++;
                $display("FAIL %s_first: got %h expected %h", tag, win_log[first_i], first_exp);
            end
            n_cmp++;
            if (win_log[last_i] !== last_exp) begin
                n_err++;
                $display("FAIL %s_final: got %h expected %h", tag, win_log[last_i], last_exp);
            end
        end
    endtask

    task automatic test_continuous();
        clear_counts();
        for (int i = 0; i < 20; i++) drive(i == 0);
        check_frame("continuous", 6, 1, 0, 5);
    endtask

    task automatic test_gaps();
        int acc;
        clear_counts();
        acc = 0;
        while (acc < 20) begin
            if ($urandom_range(0, 1) == 1) begin
                drive(acc == 0);
                acc++;
            end else begin
                idle();
            end
        end
        check_frame("gaps", 6, 1, 0, 5);
    endtask

    task automatic test_back_to_back();
        clear_counts();
        for (int i = 0; i < 40; i++) drive(i == 0 || i == 20);
        check_frame("b2b", 12, 2, 6, 11);
        n_cmp++;
        if (win_log.size() < 7 || win_log[6] !== win_log[0]) begin
            n_err++;
            $display("FAIL b2b_repeat: second frame first window differs from first frame (%0d logged)", win_log.size());
        end
    endtask

    task automatic test_sof();
        clear_counts();
        for (int i = 0; i < 13; i++) drive(i == 0);
        drive(1'b1);
        @(negedge clk);
        n_cmp++;
        if (bus.out_ready !== 1'b0) begin
            n_err++;
            $display("FAIL sof_no_window: out_ready=%b expected 0", bus.out_ready);
        end
        for (int i = 1; i < 20; i++) drive(1'b0);
        check_frame("sof", 7, 1, 1, 6);
    endtask

    task automatic test_reset_mid();
        clear_counts();
        for (int i = 0; i < 18; i++) drive(i == 0);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.out_ready !== 1'b0 || bus.out_last !== 1'b0 || bus.window !== '0) begin
            n_err++;
            $display("FAIL async_reset: ready=%b last=%b window=%h expected 0/0/0", bus.out_ready, bus.out_last, bus.window);
        end
        q.delete();
        mrow = 0;
        mcol = 0;
        repeat (2) idle();
        rst = 1'b1;
        clear_counts();
        for (int i = 0; i < 20; i++) drive(1'b0);
        check_frame("reset_mid", 6, 1, 0, 5);
    endtask

    initial begin
        bus.pixel_in = '0;
        bus.in_ready = 1'b0;
        bus.sof      = 1'b0;
        first_exp = {4'd12, 4'd11, 4'd10, 4'd7, 4'd6, 4'd5, 4'd2, 4'd1, 4'd0};
        last_exp  = {4'd3, 4'd2, 4'd1, 4'd14, 4'd13, 4'd12, 4'd9, 4'd8, 4'd7};
        test_reset();
        test_continuous();
        test_gaps();
        test_back_to_back();
        test_sof();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
